// File: rtl/seg7_mux_driver_if.sv
// Load-side bus of the 7-segment scan driver: shadow-register data inputs,
// the load strobe and the commit status flags.
interface seg7_mux_driver_if #(
    parameter int NUM_DIGITS = 8,
    parameter int BRIGHT_W   = 3
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   digit_data;
    logic [NUM_DIGITS-1:0]     char_mode;
    logic [NUM_DIGITS-1:0]     dp;
    logic [NUM_DIGITS-1:0]     blink_mask;
    logic                      lz_blank;
    logic [BRIGHT_W-1:0]       brightness;
    logic                      upd_pending;
    logic                      frame_tick;

    modport master (
        output load, digit_data, char_mode, dp, blink_mask, lz_blank, brightness,
        input  upd_pending, frame_tick
    );

    modport slave (
        input  load, digit_data, char_mode, dp, blink_mask, lz_blank, brightness,
        output upd_pending, frame_tick
    );
endinterface

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed 7-segment scan driver with frame-synchronous shadow commit,
// per-digit char/hex decode, blink, leading-zero blanking and PWM brightness.
module seg7_mux_driver #(
    parameter int NUM_DIGITS     = 8,
    parameter int CLK_HZ         = 100_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int BRIGHT_W       = 3,
    parameter int BLINK_TICKS    = 250,
    parameter int SEL_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg7_mux_driver_if.slave      bus,
    output logic [NUM_DIGITS-1:0] seg_sel,
    output logic [7:0]            seg_data
);

    localparam int DIV    = CLK_HZ / SCAN_HZ;
    localparam int STEP   = DIV >> BRIGHT_W;
    localparam int PRE_W  = (STEP > 1) ? $clog2(STEP) : 1;
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int BLK_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int DISP_W = 7 * NUM_DIGITS + 1 + BRIGHT_W;

    localparam logic [PRE_W-1:0]    PRE_MAX = PRE_W'(STEP - 1);
    localparam logic [BRIGHT_W-1:0] PH_MAX  = {BRIGHT_W{1'b1}};
    localparam logic [IDX_W-1:0]    IDX_MAX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0]    BLK_MAX = BLK_W'(BLINK_TICKS - 1);

    localparam bit SEL_INV = (SEL_ACTIVE_LOW != 0);
    localparam bit SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] SEL_IDLE = SEL_INV ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [7:0]            SEG_IDLE = SEG_INV ? 8'hFF : 8'h00;

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] data;
        logic [NUM_DIGITS-1:0]   cm;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   bm;
        logic                    lz;
        logic [BRIGHT_W-1:0]     bright;
    } disp_t;

    localparam disp_t ACTIVE_RST = disp_t'({{(DISP_W - BRIGHT_W){1'b0}}, {BRIGHT_W{1'b1}}});

    function automatic logic [6:0] decode(input logic [3:0] nib, input logic is_char);
        logic [6:0] g;
        g = 7'h00;
        if (is_char) begin
            case (nib)
                4'h1:    g = 7'h78;
                4'h2:    g = 7'h77;
                4'h3:    g = 7'h7C;
                4'h4:    g = 7'h39;
                4'h5:    g = 7'h1E;
                4'h6:    g = 7'h40;
                4'h7:    g = 7'h79;
                default: g = 7'h00;
            endcase
        end else begin
            case (nib)
                4'h0:    g = 7'h3F;
                4'h1:    g = 7'h06;
                4'h2:    g = 7'h5B;
                4'h3:    g = 7'h4F;
                4'h4:    g = 7'h66;
                4'h5:    g = 7'h6D;
                4'h6:    g = 7'h7D;
                4'h7:    g = 7'h07;
                4'h8:    g = 7'h7F;
                4'h9:    g = 7'h6F;
                4'hA:    g = 7'h77;
                4'hB:    g = 7'h7C;
                4'hC:    g = 7'h39;
                4'hD:    g = 7'h5E;
                4'hE:    g = 7'h79;
                default: g = 7'h71;
            endcase
        end
        return g;
    endfunction

    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [BRIGHT_W-1:0]   phase_q, phase_d;
    logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
    logic [BLK_W-1:0]      blink_cnt_q, blink_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic                  pend_q, pend_d;
    logic                  shown_q, shown_d;
    disp_t                 shadow_q, shadow_d;
    disp_t                 active_q, active_d;
    disp_t                 load_set;
    logic [NUM_DIGITS-1:0] seg_sel_q, seg_sel_d;
    logic [7:0]            seg_data_q, seg_data_d;

    logic pre_wrap, scan_tick, commit;
    logic lz_run;
    logic [NUM_DIGITS-1:0]      lz_supp;
    logic [NUM_DIGITS-1:0][7:0] glyph;
    logic [NUM_DIGITS-1:0]      sel_onehot;
    logic [7:0]                 data_lg;

    assign pre_wrap  = (pre_q == PRE_MAX);
    assign scan_tick = pre_wrap && (phase_q == PH_MAX);
    assign commit    = scan_tick && (scan_idx_q == IDX_MAX);
    assign load_set  = {bus.digit_data, bus.char_mode, bus.dp, bus.blink_mask,
                        bus.lz_blank, bus.brightness};

    always_comb begin
        pre_d         = pre_wrap ? '0 : pre_q + 1'b1;
        phase_d       = pre_wrap ? phase_q + 1'b1 : phase_q;
        scan_idx_d    = scan_idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (scan_tick) begin
            scan_idx_d = (scan_idx_q == IDX_MAX) ? '0 : scan_idx_q + 1'b1;
            if (blink_cnt_q == BLK_MAX) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // A load coinciding with a commit still commits the old shadow and keeps
    // the new data pending for the following frame.
    always_comb begin
        shadow_d = bus.load ? load_set : shadow_q;
        pend_d   = bus.load | (pend_q & ~commit);
        active_d = (commit && pend_q) ? shadow_q : active_q;
        shown_d  = shown_q | (commit & pend_q);
    end

    always_comb begin
        lz_run  = active_q.lz;
        lz_supp = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_run     = lz_run && !active_q.cm[i] && (active_q.data[4*i +: 4] == 4'h0);
            lz_supp[i] = lz_run;
        end
    end

    // Nothing is shown until the first commit, so a fresh reset stays dark.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign glyph[gi] =
                (!shown_q || (blink_phase_q && active_q.bm[gi])) ? 8'h00 :
                lz_supp[gi] ? {active_q.dp[gi], 7'h00} :
                {active_q.dp[gi], decode(active_q.data[4*gi +: 4], active_q.cm[gi])};
        end
    endgenerate

    always_comb begin
        sel_onehot = '0;
        data_lg    = 8'h00;
        if (phase_q <= active_q.bright) begin
            sel_onehot[scan_idx_q] = 1'b1;
            data_lg                = glyph[scan_idx_q];
        end
        seg_sel_d  = SEL_INV ? ~sel_onehot : sel_onehot;
        seg_data_d = SEG_INV ? ~data_lg : data_lg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q         <= '0;
            phase_q       <= '0;
            scan_idx_q    <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            pend_q        <= 1'b0;
            shown_q       <= 1'b0;
            shadow_q      <= '0;
            active_q      <= ACTIVE_RST;
            seg_sel_q     <= SEL_IDLE;
            seg_data_q    <= SEG_IDLE;
        end else begin
            pre_q         <= pre_d;
            phase_q       <= phase_d;
            scan_idx_q    <= scan_idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            pend_q        <= pend_d;
            shown_q       <= shown_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            seg_sel_q     <= seg_sel_d;
            seg_data_q    <= seg_data_d;
        end
    end

    assign seg_sel         = seg_sel_q;
    assign seg_data        = seg_data_q;
    assign bus.upd_pending = pend_q;
    assign bus.frame_tick  = commit;

endmodule
